// File: rtl/ysyx_25020032_pkg.sv
// Shared GPR definitions for the NPC core.
// Used by the register file, its bypass muxes and debugger-side register naming.
package ysyx_25020032_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned REG_ZERO       = 0;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH_DEF-1:0] xlen_t;

  // RISC-V ABI mnemonic for a register index (x0..x31).
  function automatic string abi_name(input logic [4:0] idx);
    string names [32];
    names = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
              "s0",   "s1", "a0", "a1", "a2", "a3", "a4", "a5",
              "a6",   "a7", "s2", "s3", "s4", "s5", "s6", "s7",
              "s8",   "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
    return names[idx];
  endfunction

endpackage

// File: rtl/ysyx_25020032_rf_bypass_mux.sv
// Per-read-port data select: zero for x0, youngest matching write when bypassing,
// otherwise the stored value. o_hit marks a bypassed read for hazard masking.
module ysyx_25020032_rf_bypass_mux
  import ysyx_25020032_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_WR      = 2,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]       i_raddr,
  input  logic [NR_WR-1:0]            i_wen,
  input  logic [NR_WR*ADDR_WIDTH-1:0] i_waddr,
  input  logic [NR_WR*DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0]       i_stored,
  output logic [DATA_WIDTH-1:0]       o_rdata,
  output logic                        o_hit
);

  logic                  w_match;
  logic [DATA_WIDTH-1:0] w_byp;
  logic                  w_zero;

  assign w_zero = (i_raddr == ADDR_WIDTH'(REG_ZERO));

  always_comb begin
    w_match = 1'b0;
    w_byp   = '0;
    // Ascending scan: the last match is the youngest write port.
    for (int unsigned j = 0; j < NR_WR; j++) begin
      if (i_wen[j] && (i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == i_raddr)) begin
        w_match = 1'b1;
        w_byp   = i_wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    o_hit = w_match && BYPASS && !w_zero;
    if (w_zero)
      o_rdata = '0;
    else if (o_hit)
      o_rdata = w_byp;
    else
      o_rdata = i_stored;
  end

endmodule

// File: rtl/ysyx_25020032_rf_scoreboard.sv
// Multi-port GPR file with per-register busy scoreboard for RAW hazard detection.
// x0 is hardwired to zero and never busy; debug port reads stored state only.
module ysyx_25020032_rf_scoreboard
  import ysyx_25020032_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_RD      = 2,
  parameter int unsigned NR_WR      = 2,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RD*DATA_WIDTH-1:0] rdata,
  output logic [NR_RD-1:0]            rbusy,
  input  logic [NR_WR-1:0]            wen,
  input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  input  logic                        flush,
  output logic                        busy_any,
  input  logic [ADDR_WIDTH-1:0]       dbg_addr,
  output logic [DATA_WIDTH-1:0]       dbg_data
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_rf [NREG];
  logic [NREG-1:0]       r_busy;
  logic [NREG-1:0]       w_busy_nxt;
  logic                  w_clr;
  logic [NR_WR-1:0]      w_wen_byp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++)
        r_rf[ADDR_WIDTH'(r)] <= '0;
    end else begin
      for (int unsigned j = 0; j < NR_WR; j++) begin
        if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO)))
          r_rf[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Priority per register: flush > issue (set) > writeback (clear) > hold.
  always_comb begin
    w_busy_nxt = r_busy;
    w_clr      = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      w_clr = 1'b0;
      for (int unsigned j = 0; j < NR_WR; j++) begin
        if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)))
          w_clr = 1'b1;
      end
      if (flush)
        w_busy_nxt[ADDR_WIDTH'(r)] = 1'b0;
      else if (iss_valid && (iss_rd == ADDR_WIDTH'(r)))
        w_busy_nxt[ADDR_WIDTH'(r)] = 1'b1;
      else if (w_clr)
        w_busy_nxt[ADDR_WIDTH'(r)] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  // Writes in flight during reset must not bypass onto rdata.
  assign w_wen_byp = rst ? '0 : wen;

  for (genvar g = 0; g < NR_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_hit;

    assign w_ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

    ysyx_25020032_rf_bypass_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NR_WR      (NR_WR),
      .BYPASS     (BYPASS)
    ) u_mux (
      .i_raddr  (w_ra),
      .i_wen    (w_wen_byp),
      .i_waddr  (waddr),
      .i_wdata  (wdata),
      .i_stored (r_rf[w_ra]),
      .o_rdata  (rdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_hit    (w_hit)
    );

    assign rbusy[g] = r_busy[w_ra] && !w_hit;
  end

  assign busy_any = |r_busy;
  assign dbg_data = r_rf[dbg_addr];

endmodule
